uart_packet_parser: RTL
=======================

Name: uart_packet_parser

Overview:
- Consumes bytes from the UART receive FIFO through its rx_rdy/next_rx/rx_data pop interface.
- Hunts for a sync byte, then parses a length-prefixed frame and checks an XOR checksum.
- Buffers the payload and releases it to downstream logic on a valid/ready byte stream only after the checksum passes. A frame that fails the checksum never reaches downstream logic.
- Sits directly downstream of the UART receiver in the clk domain.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 16: maximum payload bytes; also the depth of the payload buffer (1..255).
- TIMEOUT, 16'd50000: maximum clk cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_rdy  in  1  receive FIFO non-empty.
- rx_data  in  8  receive FIFO read data; valid in the clk cycle after a next_rx pulse.
- next_rx  out  1  one-cycle FIFO pop request.
- pkt_data  out  8  payload byte.
- pkt_valid  out  1  pkt_data is valid.
- pkt_last  out  1  final payload byte of the frame.
- pkt_ready  in  1  downstream accepts the byte.
- frame_good  out  1  one-cycle pulse when the checksum passes.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- err_code  out  2  reason for the last abort; holds until the next abort.
- good_count  out  8  count of good frames, wraps at 255.

Behaviour:
- Reset: every output is 0; the FSM enters HUNT; the fetch engine is idle; the timeout counter is 0. Reset mid-frame or mid-EMIT discards the frame with no frame_err.
- Frame format: SYNC, LEN, LEN payload bytes, CHK. Valid LEN is 1..MAX_LEN. CHK must equal the XOR of LEN and all payload bytes.
- Fetch engine:
  - Pulses next_rx for one cycle when rx_rdy=1, the FSM is in HUNT/LEN/PAYLOAD/CHK, and no pop is outstanding.
  - On the next cycle it captures rx_data and asserts byte_valid for one cycle.
  - It never asserts next_rx in the same cycle as byte_valid, so there is at most one pop every 2 cycles.
  - It never pops in EMIT; the FIFO absorbs the back-pressure.
- FSM states:
  - HUNT: a byte equal to SYNC goes to LEN; any other byte is discarded.
  - LEN: if the byte is 0 or greater than MAX_LEN, abort with err_code=1. Otherwise latch the length, set chk=byte, clear the write index, and go to PAYLOAD.
  - PAYLOAD: write the byte to buf[idx], chk^=byte, idx++. After the LENth byte, go to CHK.
  - CHK: if the byte equals chk, pulse frame_good, increment good_count, and go to EMIT. Otherwise abort with err_code=2.
  - EMIT: drive buf[rd] with pkt_valid=1. pkt_last=1 when rd==len-1. Advance rd on pkt_valid&pkt_ready. pkt_data and pkt_last stay stable while pkt_valid&!pkt_ready. After the last byte is accepted, pkt_valid drops on the next cycle and the FSM returns to HUNT.
- Abort: pulse frame_err for one cycle, update err_code, return to HUNT. Payload is never emitted for an aborted frame.
- Timeout:
  - The counter clears on each byte_valid.
  - It increments every cycle in LEN, PAYLOAD and CHK without a byte_valid.
  - When it reaches TIMEOUT (and TIMEOUT≠0), abort with err_code=3.
  - The counter is held at 0 in HUNT and EMIT.
- A SYNC value appearing inside LEN, PAYLOAD or CHK is data; there is no resynchronisation mid-frame.
- Frame latency: frame_good is asserted in the cycle after the CHK byte_valid. The first pkt_valid is asserted in the same cycle as frame_good.

Decomposition:
- Shared package: the FSM state encodings (HUNT, LEN, PAYLOAD, CHK, EMIT), the err_code constants (ERR_NONE=0, ERR_LEN=1, ERR_CHK=2, ERR_TIMEOUT=3), and SYNC_BYTE.
- One sub-module: uart_byte_fetch. It owns next_rx, the outstanding-pop flag, and the byte/byte_valid capture register, with an enable input driven by the FSM.

Test Plan:
- Good frame: FIFO bytes A5 03 11 22 33 03, pkt_ready=1 → frame_good pulses once; stream 11,22,33 with pkt_last only on 33; good_count=1; no frame_err.
- Garbage then frame: bytes 00 FF 5A A5 01 7E 7F → three bytes silently discarded; output 7E with pkt_last=1; good_count increments.
- Checksum and length errors:
  - A5 02 AA 55 00 → frame_err, err_code=2, no pkt_valid.
  - A5 00 → err_code=1.
  - A5 11 with MAX_LEN=16 → err_code=1; the next valid frame still parses.
- Back-pressure: good 4-byte frame with pkt_ready low for 5 cycles on byte 2 → pkt_data and pkt_last held; next_rx stays 0 throughout EMIT; a queued next frame is parsed afterwards.
- Timeout: TIMEOUT=20, bytes A5 02 AA then rx_rdy=0 → frame_err with err_code=3 exactly 20 cycles after the AA byte_valid; FSM in HUNT.
- Reset mid-PAYLOAD and mid-EMIT → next cycle every output is 0 and no frame_err; a following good frame parses normally.

Source files
------------

// File: rtl/uart_packet_parser_pkg.sv
// Shared types and constants for the UART packet parser.
// FSM state encodings, abort reason codes and the default frame marker.
package uart_packet_parser_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_EMIT
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_packet_parser_byte_fetch.sv
// Pops bytes from the UART receive FIFO, one outstanding pop at a time.
// Popped data is registered and presented as a one-cycle byte_valid strobe.
module uart_byte_fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       next_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  logic pending_q;

  // No new pop while a byte is in flight or being handed over.
  assign next_rx = en & rx_rdy & ~pending_q & ~byte_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
    end else begin
      pending_q  <= next_rx;
      byte_valid <= pending_q;
      if (pending_q) byte_data <= rx_data;
    end
  end

endmodule

// File: rtl/uart_packet_parser.sv
// Sync-hunting, length-prefixed frame parser with XOR checksum.
// Payload is buffered and streamed out only after the checksum passes.
module uart_packet_parser #(
  parameter logic [7:0]  SYNC_BYTE = uart_packet_parser_pkg::SYNC_BYTE,
  parameter int          MAX_LEN   = 16,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       next_rx,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic       frame_good,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] good_count
);
  import uart_packet_parser_pkg::*;

  localparam int         IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  rd_q, rd_d;
  logic [15:0] tmo_q;
  logic [7:0]  pbuf [2**IW];
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        fetch_en;
  logic        in_frame;
  logic        tmo_hit;
  logic        good_d, err_d, wr_en;
  logic [1:0]  code_d;

  assign fetch_en = (state_q != ST_EMIT);
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                    (state_q == ST_CHK);
  // Fires so that frame_err lands TIMEOUT cycles after the last byte.
  assign tmo_hit  = (TIMEOUT != 16'd0) &&
                    (({1'b0, tmo_q} + 17'd2) >= {1'b0, TIMEOUT});

  uart_byte_fetch u_fetch (
    .clk       (clk),
    .reset     (reset),
    .en        (fetch_en),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .next_rx   (next_rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    code_d  = err_code;
    case (state_q)
      ST_HUNT: begin
        if (byte_valid && byte_data == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (byte_valid) begin
          if (byte_data == 8'd0 || byte_data > MAX_B) begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            len_d   = byte_data;
            chk_d   = byte_data;
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end
        end else if (tmo_hit) begin
          state_d = ST_HUNT;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_PAYLOAD: begin
        if (byte_valid) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ byte_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = ST_CHK;
        end else if (tmo_hit) begin
          state_d = ST_HUNT;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_CHK: begin
        if (byte_valid) begin
          if (byte_data == chk_q) begin
            good_d  = 1'b1;
            rd_d    = 8'd0;
            state_d = ST_EMIT;
          end else begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
            code_d  = ERR_CHK;
          end
        end else if (tmo_hit) begin
          state_d = ST_HUNT;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_EMIT: begin
        if (pkt_ready) begin
          if (rd_q == len_q - 8'd1) state_d = ST_HUNT;
          else rd_d = rd_q + 8'd1;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      len_q      <= 8'd0;
      chk_q      <= 8'd0;
      idx_q      <= 8'd0;
      rd_q       <= 8'd0;
      tmo_q      <= 16'd0;
      frame_good <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      good_count <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      tmo_q      <= (in_frame && !byte_valid) ? tmo_q + 16'd1 : 16'd0;
      frame_good <= good_d;
      frame_err  <= err_d;
      err_code   <= code_d;
      if (good_d) good_count <= good_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pbuf[idx_q[IW-1:0]] <= byte_data;
  end

  assign pkt_valid = (state_q == ST_EMIT);
  assign pkt_data  = pkt_valid ? pbuf[rd_q[IW-1:0]] : 8'h00;
  assign pkt_last  = pkt_valid && (rd_q == len_q - 8'd1);

endmodule
